// File: rtl/sort_serializer_if.sv
// Handshake bundle between the sorter output register and the lane serializer.
// The slave modport is the serializer's view; the master modport is its environment.
interface sort_serializer_if #(
  parameter int NUM_VALS = 5,
  parameter int SIZE     = 16
);
  localparam int IDX_W = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;

  logic [NUM_VALS*SIZE-1:0] in;
  logic                     in_valid;
  logic                     in_ready;
  logic [SIZE-1:0]          out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_index;
  logic                     out_last;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_index, out_last
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_index, out_last
  );
endinterface

// File: rtl/sort_serializer.sv
// Captures one descending-sorted frame of NUM_VALS lanes and streams it out lane 0 first,
// reloading on the final-lane handshake so consecutive frames stream without a bubble.
module sort_serializer #(
  parameter int NUM_VALS = 5,
  parameter int SIZE     = 16
) (
  input  logic               clk,
  input  logic               rst,
  sort_serializer_if.slave   bus
);
  localparam int              IDX_W    = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALS - 1);

  typedef enum logic {IDLE, SEND} state_e;
  typedef logic [NUM_VALS-1:0][SIZE-1:0] frame_t;

  state_e           state_q, state_d;
  frame_t           buf_q, buf_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [SIZE-1:0]  out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             xfer;
  logic             in_ready;
  logic             capture;

  assign xfer     = out_valid_q & bus.out_ready;
  // A new frame may enter while idle or exactly as the final lane leaves.
  assign in_ready = ~rst & ((state_q == IDLE) | (xfer & out_last_q));
  assign capture  = bus.in_valid & in_ready;
  assign idx_nxt  = idx_q + IDX_W'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: ;
      SEND: begin
        if (xfer) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            idx_d       = '0;
          end else begin
            idx_d       = idx_nxt;
            out_data_d  = buf_q[idx_nxt];
            out_last_d  = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture overrides the end-of-frame return to IDLE, giving the no-gap handover.
    if (capture) begin
      state_d     = SEND;
      buf_d       = bus.in;
      idx_d       = '0;
      out_data_d  = bus.in[SIZE-1:0];
      out_valid_d = 1'b1;
      out_last_d  = (LAST_IDX == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      // NOTE: the frame buffer is cleared too, so an aborted frame can never resurface.
      buf_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = idx_q;
  assign bus.out_last  = out_last_q;

  a_valid_tracks_state: assert property (@(posedge clk) disable iff (rst)
    out_valid_q == (state_q == SEND));

  a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
    idx_q <= LAST_IDX);

  a_last_flag: assert property (@(posedge clk) disable iff (rst)
    out_last_q == (out_valid_q && (idx_q == LAST_IDX)));

  a_hold_under_stall: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=>
      ($stable(out_data_q) && $stable(idx_q) && $stable(out_last_q) && out_valid_q));
endmodule
